// File: rtl/hazard_stall_unit.sv
// Pipeline stall/flush control: load-use interlock, data-memory wait freeze with timeout,
// branch IF/ID flush, and saturating stall/flush statistics.
module hazard_stall_unit #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IF_ID_RsAddr_i,
  input  logic [4:0]       IF_ID_RtAddr_i,
  input  logic             ID_UsesRt_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [4:0]       ID_EX_RtAddr_i,
  input  logic             Branch_Taken_i,
  input  logic             DMem_Req_i,
  input  logic             DMem_Ready_i,
  output logic             PC_Write_o,
  output logic             IF_ID_Write_o,
  output logic             IF_ID_Flush_o,
  output logic             ID_EX_Bubble_o,
  output logic             Pipe_Freeze_o,
  output logic             MEM_WB_Bubble_o,
  output logic             Error_o,
  output logic [CNT_W-1:0] StallCycles_o,
  output logic [CNT_W-1:0] FlushCount_o
);

  localparam int unsigned WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                mem_stall;
  logic                load_use;

  assign mem_stall = DMem_Req_i & ~DMem_Ready_i;
  assign load_use  = ID_EX_MemRead_i & (ID_EX_RtAddr_i != 5'd0) &
                     ((ID_EX_RtAddr_i == IF_ID_RsAddr_i) |
                      (ID_UsesRt_i & (ID_EX_RtAddr_i == IF_ID_RtAddr_i)));

  // State and wait counter registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next state and Mealy control outputs; memory freeze outranks the load-use bubble,
  // which outranks the branch flush (the branch re-resolves once the stall clears).
  always_comb begin
    state_d         = state_q;
    wait_d          = wait_q;
    PC_Write_o      = 1'b1;
    IF_ID_Write_o   = 1'b1;
    IF_ID_Flush_o   = 1'b0;
    ID_EX_Bubble_o  = 1'b0;
    Pipe_Freeze_o   = 1'b0;
    MEM_WB_Bubble_o = 1'b0;

    case (state_q)
      ST_ERROR: begin
        PC_Write_o      = 1'b0;
        IF_ID_Write_o   = 1'b0;
        Pipe_Freeze_o   = 1'b1;
        MEM_WB_Bubble_o = 1'b1;
      end
      default: begin
        if (mem_stall) begin
          PC_Write_o      = 1'b0;
          IF_ID_Write_o   = 1'b0;
          Pipe_Freeze_o   = 1'b1;
          MEM_WB_Bubble_o = 1'b1;
        end else if (load_use) begin
          PC_Write_o     = 1'b0;
          IF_ID_Write_o  = 1'b0;
          ID_EX_Bubble_o = 1'b1;
        end else if (Branch_Taken_i) begin
          IF_ID_Flush_o = 1'b1;
        end

        if (state_q == ST_RUN) begin
          if (mem_stall) begin
            state_d = ST_MEM_WAIT;
            wait_d  = WAIT_W'(1);
          end
        end else if (mem_stall) begin
          if (wait_q == WAIT_W'(TIMEOUT)) begin
            state_d = ST_ERROR;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end else begin
          // Ready, or the request dropped: the access is complete
          state_d = ST_RUN;
          wait_d  = '0;
        end
      end
    endcase
  end

  assign Error_o = (state_q == ST_ERROR);

  // Saturating statistics counters
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      StallCycles_o <= '0;
      FlushCount_o  <= '0;
    end else begin
      if (!PC_Write_o && (StallCycles_o != {CNT_W{1'b1}})) begin
        StallCycles_o <= StallCycles_o + CNT_W'(1);
      end
      if (IF_ID_Flush_o && (FlushCount_o != {CNT_W{1'b1}})) begin
        FlushCount_o <= FlushCount_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit (TIMEOUT=4, CNT_W=3): expected control vectors and
// counter values are queued per step and checked against the DUT mid-cycle.
module tb_hazard_stall_unit;

  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 3;

  // {pc_write, if_id_write, flush, id_ex_bubble, freeze, mem_wb_bubble, error}
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic flush;
    logic bubble;
    logic freeze;
    logic wb_bubble;
    logic error;
  } ctl_t;

  typedef struct packed {
    ctl_t             ctl;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flushes;
  } exp_t;

  localparam ctl_t NORM = 7'b1100000;
  localparam ctl_t LU   = 7'b0001000;
  localparam ctl_t BR   = 7'b1110000;
  localparam ctl_t MW   = 7'b0000110;
  localparam ctl_t ER   = 7'b0000111;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic clk = 1'b0;
  logic rst_i;
  logic [4:0] rs, rt, ex_rt;
  logic uses_rt, memread, br, req, rdy;
  logic pc_write, if_id_write, flush, bubble, freeze, wb_bubble, error;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .IF_ID_RsAddr_i (rs),
    .IF_ID_RtAddr_i (rt),
    .ID_UsesRt_i    (uses_rt),
    .ID_EX_MemRead_i(memread),
    .ID_EX_RtAddr_i (ex_rt),
    .Branch_Taken_i (br),
    .DMem_Req_i     (req),
    .DMem_Ready_i   (rdy),
    .PC_Write_o     (pc_write),
    .IF_ID_Write_o  (if_id_write),
    .IF_ID_Flush_o  (flush),
    .ID_EX_Bubble_o (bubble),
    .Pipe_Freeze_o  (freeze),
    .MEM_WB_Bubble_o(wb_bubble),
    .Error_o        (error),
    .StallCycles_o  (stall_cnt),
    .FlushCount_o   (flush_cnt)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One cycle: drive at posedge+1, queue the expectation, compare at negedge
  task automatic step(input string tag, input logic [4:0] s_rs, input logic [4:0] s_rt,
                      input logic s_uses, input logic s_mr, input logic [4:0] s_exrt,
                      input logic s_br, input logic s_req, input logic s_rdy, input ctl_t e);
    exp_t item;
    exp_t got;
    rs = s_rs; rt = s_rt; uses_rt = s_uses; memread = s_mr; ex_rt = s_exrt;
    br = s_br; req = s_req; rdy = s_rdy;
    item.ctl = e; item.stall = m_stall; item.flushes = m_flush;
    exp_q.push_back(item);
    @(negedge clk);
    got = exp_q.pop_front();
    chk({tag, "_ctl"}, 8'({pc_write, if_id_write, flush, bubble, freeze, wb_bubble, error}),
        8'(got.ctl));
    chk({tag, "_stall"}, 8'(stall_cnt), 8'(got.stall));
    chk({tag, "_flush"}, 8'(flush_cnt), 8'(got.flushes));
    if (!e.pc_write && m_stall != CMAX) m_stall = m_stall + CNT_W'(1);
    if (e.flush && m_flush != CMAX) m_flush = m_flush + CNT_W'(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NORM);
  endtask

  // Asynchronous reset mid-cycle; effects must appear with no clock edge
  task automatic async_reset(input string tag);
    rst_i = 1'b0;
    #2;
    chk({tag, "_err"}, 8'(error), 8'd0);
    chk({tag, "_stall"}, 8'(stall_cnt), 8'd0);
    chk({tag, "_flush"}, 8'(flush_cnt), 8'd0);
    m_stall = '0;
    m_flush = '0;
    rs = '0; rt = '0; uses_rt = 1'b0; memread = 1'b0; ex_rt = '0;
    br = 1'b0; req = 1'b0; rdy = 1'b0;
    #1;
    rst_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b0;
    rs = '0; rt = '0; uses_rt = 1'b0; memread = 1'b0; ex_rt = '0;
    br = 1'b0; req = 1'b0; rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;

    idle("reset");
    step("lu_rs", 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, LU);
    idle("lu_after");
    step("zero_reg", 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, NORM);
    step("rt_unused", 5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, NORM);
    step("rt_used", 5'd0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, LU);
    step("branch", 5'd1, 5'd2, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, BR);
    step("branch_lu", 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, LU);
    idle("post_branch");

    // Three frozen cycles (branch suppressed in one), then the unfrozen ready cycle
    step("mw1", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MW);
    step("mw2", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, MW);
    step("mw3", 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, MW);
    step("mw_ready", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NORM);
    idle("mw_done");
    step("mw_req_drop1", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MW);
    step("mw_req_drop2", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, BR);
    step("ready_no_req", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NORM);
    idle("mw_idle");

    async_reset("rst_sat");
    for (int i = 0; i < 10; i++) begin
      step("sat_lu", 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, LU);
    end
    idle("sat_end");
    chk("sat_value", 8'(stall_cnt), 8'd7);

    async_reset("rst_to");
    for (int i = 0; i < int'(TIMEOUT) + 1; i++) begin
      step("to_wait", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MW);
    end
    step("to_err", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, ER);
    step("err_ready", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, ER);
    step("err_branch", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, ER);
    async_reset("rst_err");
    idle("after_err");
    step("after_err_br", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, BR);
    idle("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
